fft_bfly_r2_pipe: RTL and testbench
===================================

Name: fft_bfly_r2_pipe

Overview:
- Parametrised radix-2 trivial-twiddle butterfly stage for the FFT datapath; processes LANES complex samples per beat.
- Pairs lane i with lane i+STRIDE inside each group of 2*STRIDE lanes.
- Applies optional -j rotation to the upper half of each difference group. Two-stage pipeline with valid/ready backpressure and frame tracking.
- Drop-in successor stage between the input reorder buffer and the first twiddle multiplier.

Parameters:
- IN_W, 13, input sample width (signed, per real/imag component); OUT_W = IN_W+1.
- LANES, 16, complex lanes per beat; power of two, >= 2.
- STRIDE, 4, butterfly span; power of two, 1 <= STRIDE <= LANES/2.
- FRAME_BEATS, 32, accepted beats per FFT frame; >= 2.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat.
- in_sof  in  1  first beat of a frame (qualified by in_valid&&in_ready).
- in_real / in_imag  in  LANES x IN_W  signed sample arrays.
- rot_en  in  1  enables -j rotation; sampled with each beat and carried with it.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_sof / out_eof  out  1  frame markers aligned to out data.
- out_real / out_imag  out  LANES x OUT_W  signed results.
- frame_err  out  1  sticky framing error.
- err_clr  in  1  synchronous clear of frame_err.

Behaviour:
- Reset state: all valids 0; out data, sof/eof, frame_err and beat counter 0.
- Index mapping: for lane k, let g = k div (2*STRIDE) and p = k mod (2*STRIDE).
  - If p < STRIDE, then out[k] = x[k] + x[k+STRIDE].
  - Otherwise, d = x[k-STRIDE] - x[k].
    - If rot_en and (p-STRIDE) >= STRIDE/2, out = -j*d, i.e. real = d.imag, imag = -d.real.
    - Otherwise out = d.
  - For STRIDE=1, no lane is rotated.
- Arithmetic: sign-extend to OUT_W before add/sub. No overflow is possible, including negation of d (|d| <= 2^IN_W - 1).
- Pipeline:
  - S1 registers sums/differences plus rot_en and markers.
  - S2 applies rotation and drives the outputs directly from registers.
  - Latency is 2 cycles from accepted input to out_valid when unstalled. Throughput is 1 beat/cycle.
- Handshake:
  - s2_load = !out_valid || out_ready.
  - s1_load = !s1_valid || s2_load.
  - in_ready = s1_load.
  - A beat transfers on valid&&ready. Output data and markers are held stable while out_valid && !out_ready.
  - A bubble in S1 still lets S2 drain.
- Frame counter (beat_cnt, 0..FRAME_BEATS-1):
  - Increments on every accepted beat and wraps to 0.
  - If in_sof is set on an accepted beat, that beat is index 0 and the counter becomes 1.
  - out_sof = beat index 0; out_eof = index FRAME_BEATS-1.
- frame_err:
  - Set when an accepted in_sof arrives while beat_cnt != 0 (premature SOF).
  - Set when an accepted beat arrives at beat_cnt == 0 without in_sof.
  - err_clr and a set event in the same cycle: set wins.
- Reset mid-operation: in-flight beats are discarded, counter returns to 0, and no partial output is presented.

Optional Feature:
- Macro FFT_BFLY_SCALE_EN.
  - Defined: adds input port scale_half (1 bit, carried per beat). When 1, S2 outputs (v + 1) >>> 1 per component, arithmetic, computed at OUT_W+1 and truncated back to OUT_W. Cannot overflow.
  - Undefined: port absent; outputs unscaled.

Decomposition:
- Package fft_pkg: IN_W/OUT_W defaults, typedef of the signed sample types, helper function for lane pairing, rotation predicate.
- One sub-module, fft_bfly_core: purely combinational sum/difference for all lanes. The top holds the pipeline, handshake, counter and rotation.

Test Plan:
- Reset then single beat, LANES=16, STRIDE=4, rot_en=1, lane0=100+20j, lane4=30-5j, lane2=7+3j, lane6=1+1j:
  - out0 = 130+15j, out4 = 70+25j, out6 = 2-6j (rotated).
  - out_valid asserted exactly 2 cycles after acceptance.
- Extremes: all inputs -4096 real, lane4..7 = +4095:
  - sums -8192.
  - Rotated diff imag = +8191, no wrap.
- Backpressure: stream 10 beats with out_ready toggled 1-0-0-1…; every beat is delivered once, in order, with data held while stalled; in_ready drops only when both stages are full.
- Frame of 32 beats with in_sof on beat 0: out_sof on output 0, out_eof on output 31, frame_err=0. A second in_sof at beat 5 sets frame_err; err_clr clears it.
- rstn asserted with 2 beats in flight: out_valid=0 immediately; after release, the next beat without in_sof sets frame_err.
- FFT_BFLY_SCALE_EN, scale_half=1: sum 130 -> 65, value -3 -> -1, value 8191 -> 4096.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and lane-pairing helpers for the radix-2 butterfly datapath.
// Used by fft_bfly_core and fft_bfly_r2_pipe.
package fft_pkg;

  localparam int IN_W_DEF  = 13;
  localparam int OUT_W_DEF = IN_W_DEF + 1;

  typedef logic signed [IN_W_DEF-1:0]  smp_in_t;
  typedef logic signed [OUT_W_DEF-1:0] smp_out_t;

  // Lane k is in the upper (difference) half of its group.
  function automatic bit is_diff_lane(int k, int stride);
    return (k % (2 * stride)) >= stride;
  endfunction

  // Partner lane of k within its group of 2*stride lanes.
  function automatic int pair_lane(int k, int stride);
    return is_diff_lane(k, stride) ? k - stride : k + stride;
  endfunction

  // Difference lanes in the upper half of their span take the -j rotation.
  function automatic bit rot_lane(int k, int stride);
    return (stride > 1) && is_diff_lane(k, stride) &&
           (((k % (2 * stride)) - stride) >= stride / 2);
  endfunction

endpackage

// File: rtl/fft_bfly_core.sv
// Combinational radix-2 sum/difference across all lanes.
// Lower half of each group gets sums, upper half gets differences.
module fft_bfly_core
  import fft_pkg::*;
#(
  parameter  int IN_W   = IN_W_DEF,
  parameter  int LANES  = 16,
  parameter  int STRIDE = 4,
  localparam int OUT_W  = IN_W + 1
) (
  input  logic [LANES*IN_W-1:0]  x_re,
  input  logic [LANES*IN_W-1:0]  x_im,
  output logic [LANES*OUT_W-1:0] y_re,
  output logic [LANES*OUT_W-1:0] y_im
);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam int PL = pair_lane(k, STRIDE);
    localparam bit DF = is_diff_lane(k, STRIDE);
    localparam int LO = DF ? PL : k;
    localparam int HI = DF ? k : PL;

    logic [OUT_W-1:0] lo_re;
    logic [OUT_W-1:0] lo_im;
    logic [OUT_W-1:0] hi_re;
    logic [OUT_W-1:0] hi_im;

    assign lo_re = {x_re[LO*IN_W+IN_W-1], x_re[LO*IN_W +: IN_W]};
    assign lo_im = {x_im[LO*IN_W+IN_W-1], x_im[LO*IN_W +: IN_W]};
    assign hi_re = {x_re[HI*IN_W+IN_W-1], x_re[HI*IN_W +: IN_W]};
    assign hi_im = {x_im[HI*IN_W+IN_W-1], x_im[HI*IN_W +: IN_W]};

    if (DF) begin : g_diff
      assign y_re[k*OUT_W +: OUT_W] = lo_re - hi_re;
      assign y_im[k*OUT_W +: OUT_W] = lo_im - hi_im;
    end else begin : g_sum
      assign y_re[k*OUT_W +: OUT_W] = lo_re + hi_re;
      assign y_im[k*OUT_W +: OUT_W] = lo_im + hi_im;
    end
  end

endmodule

// File: rtl/fft_bfly_r2_pipe.sv
// Two-stage radix-2 butterfly with -j rotation, handshake and framing.
// Optional FFT_BFLY_SCALE_EN adds per-beat scale_half rounding.
module fft_bfly_r2_pipe
  import fft_pkg::*;
#(
  parameter  int IN_W        = IN_W_DEF,
  parameter  int LANES       = 16,
  parameter  int STRIDE      = 4,
  parameter  int FRAME_BEATS = 32,
  localparam int OUT_W       = IN_W + 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sof,
  input  logic [LANES*IN_W-1:0]  in_real,
  input  logic [LANES*IN_W-1:0]  in_imag,
  input  logic                   rot_en,
`ifdef FFT_BFLY_SCALE_EN
  input  logic                   scale_half,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sof,
  output logic                   out_eof,
  output logic [LANES*OUT_W-1:0] out_real,
  output logic [LANES*OUT_W-1:0] out_imag,
  output logic                   frame_err,
  input  logic                   err_clr
);

  localparam int CW = $clog2(FRAME_BEATS);
  localparam int LW = LANES * OUT_W;
  localparam logic [CW-1:0] LAST = CW'(FRAME_BEATS - 1);

  logic          s1_valid;
  logic [LW-1:0] s1_re;
  logic [LW-1:0] s1_im;
  logic          s1_rot;
  logic          s1_sof;
  logic          s1_eof;
`ifdef FFT_BFLY_SCALE_EN
  logic          s1_scale;
`endif

  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] beat_idx;
  logic          s2_load;
  logic          s1_load;
  logic          in_fire;
  logic          err_set;
  logic [LW-1:0] core_re;
  logic [LW-1:0] core_im;
  logic [LW-1:0] s2_re;
  logic [LW-1:0] s2_im;

  assign s2_load  = !out_valid || out_ready;
  assign s1_load  = !s1_valid || s2_load;
  assign in_ready = s1_load;
  assign in_fire  = in_valid && s1_load;
  assign beat_idx = in_sof ? '0 : beat_cnt;
  assign err_set  = in_fire &&
                    (in_sof ? (beat_cnt != '0) : (beat_cnt == '0));

  fft_bfly_core #(
    .IN_W   (IN_W),
    .LANES  (LANES),
    .STRIDE (STRIDE)
  ) u_core (
    .x_re (in_real),
    .x_im (in_imag),
    .y_re (core_re),
    .y_im (core_im)
  );

`ifdef FFT_BFLY_SCALE_EN
  function automatic logic [OUT_W-1:0] half_rnd(
    input logic [OUT_W-1:0] v
  );
    logic [OUT_W:0] t;
    t = {v[OUT_W-1], v} + (OUT_W+1)'(1);
    return t[OUT_W:1];
  endfunction
`endif

  // Stage 2 next value: rotate upper difference lanes, then scale.
  always_comb begin
    s2_re = s1_re;
    s2_im = s1_im;
    for (int k = 0; k < LANES; k++) begin
      if (s1_rot && rot_lane(k, STRIDE)) begin
        s2_re[k*OUT_W +: OUT_W] = s1_im[k*OUT_W +: OUT_W];
        s2_im[k*OUT_W +: OUT_W] = -s1_re[k*OUT_W +: OUT_W];
      end
`ifdef FFT_BFLY_SCALE_EN
      if (s1_scale) begin
        s2_re[k*OUT_W +: OUT_W] = half_rnd(s2_re[k*OUT_W +: OUT_W]);
        s2_im[k*OUT_W +: OUT_W] = half_rnd(s2_im[k*OUT_W +: OUT_W]);
      end
`endif
    end
  end

  // Stage 1: capture sums/differences with beat attributes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_re    <= '0;
      s1_im    <= '0;
      s1_rot   <= 1'b0;
      s1_sof   <= 1'b0;
      s1_eof   <= 1'b0;
`ifdef FFT_BFLY_SCALE_EN
      s1_scale <= 1'b0;
`endif
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_fire) begin
        s1_re  <= core_re;
        s1_im  <= core_im;
        s1_rot <= rot_en;
        s1_sof <= (beat_idx == '0);
        s1_eof <= (beat_idx == LAST);
`ifdef FFT_BFLY_SCALE_EN
        s1_scale <= scale_half;
`endif
      end
    end
  end

  // Frame position and sticky framing error; set beats clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_cnt  <= '0;
      frame_err <= 1'b0;
    end else begin
      if (in_fire)
        beat_cnt <= (beat_idx == LAST) ? '0 : beat_idx + CW'(1);
      if (err_set)
        frame_err <= 1'b1;
      else if (err_clr)
        frame_err <= 1'b0;
    end
  end

  // Stage 2: output registers, held while downstream stalls.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_real  <= '0;
      out_imag  <= '0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_real <= s2_re;
        out_imag <= s2_im;
        out_sof  <= s1_sof;
        out_eof  <= s1_eof;
      end
    end
  end

endmodule

// File: tb/tb_fft_bfly_r2_pipe.sv
// Scoreboard bench for fft_bfly_r2_pipe (LANES=16, STRIDE=4).
// Build with FFT_BFLY_SCALE_EN to exercise scale_half.
module tb_fft_bfly_r2_pipe;

  localparam int IN_W  = 13;
  localparam int OUT_W = 14;
  localparam int LANES = 16;
  localparam int S     = 4;
  localparam int FB    = 32;
  localparam int IW    = LANES * IN_W;
  localparam int LW    = LANES * OUT_W;

  typedef struct {
    logic [LW-1:0] re;
    logic [LW-1:0] im;
    logic          sof;
    logic          eof;
  } exp_t;

  logic          clk = 0;
  logic          rstn = 0;
  logic          in_valid = 0;
  logic          in_ready;
  logic          in_sof = 0;
  logic [IW-1:0] in_real = '0;
  logic [IW-1:0] in_imag = '0;
  logic          rot_en = 0;
  logic          out_valid;
  logic          out_ready = 1;
  logic          out_sof;
  logic          out_eof;
  logic [LW-1:0] out_real;
  logic [LW-1:0] out_imag;
  logic          frame_err;
  logic          err_clr = 0;
`ifdef FFT_BFLY_SCALE_EN
  logic          scale_half = 0;
`endif

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   acc_n = 0;
  int   del_n = 0;
  int   tb_cnt = 0;
  int   rdy_mode = 0;
  int   pc = 0;
  bit   stalled = 0;
  logic [LW-1:0] held_re;
  logic [LW-1:0] held_im;
  logic          held_sof;

  fft_bfly_r2_pipe #(
    .IN_W        (IN_W),
    .LANES       (LANES),
    .STRIDE      (S),
    .FRAME_BEATS (FB)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sof    (in_sof),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .rot_en    (rot_en),
`ifdef FFT_BFLY_SCALE_EN
    .scale_half(scale_half),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .frame_err (frame_err),
    .err_clr   (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [511:0] act,
                       input logic [511:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, req);
  endtask

  function automatic logic [IW-1:0] pat(int n, int salt);
    logic [IW-1:0] r;
    int v;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      v = ((n * 37 + k * 113 + salt * 511) % 8192) - 4096;
      r[k*IN_W +: IN_W] = v[IN_W-1:0];
    end
    return r;
  endfunction

  task automatic model(input logic [IW-1:0] xr, input logic [IW-1:0] xi,
                       input logic rot, input logic sc,
                       output logic [LW-1:0] yr, output logic [LW-1:0] yi);
    yr = '0;
    yi = '0;
    for (int k = 0; k < LANES; k++) begin
      int p, lo, hi, ar, ai, br, bi, vr, vi, tmp;
      logic signed [IN_W-1:0] t;
      p  = k % (2 * S);
      lo = (p < S) ? k : k - S;
      hi = (p < S) ? k + S : k;
      t = xr[lo*IN_W +: IN_W]; ar = t;
      t = xi[lo*IN_W +: IN_W]; ai = t;
      t = xr[hi*IN_W +: IN_W]; br = t;
      t = xi[hi*IN_W +: IN_W]; bi = t;
      if (p < S) begin
        vr = ar + br; vi = ai + bi;
      end else begin
        vr = ar - br; vi = ai - bi;
        if (rot && S > 1 && (p - S) >= S / 2) begin
          tmp = vr; vr = vi; vi = -tmp;
        end
      end
      if (sc) begin
        vr = (vr + 1) >>> 1;
        vi = (vi + 1) >>> 1;
      end
      yr[k*OUT_W +: OUT_W] = vr[OUT_W-1:0];
      yi[k*OUT_W +: OUT_W] = vi[OUT_W-1:0];
    end
  endtask

  task automatic send_exp(input logic [IW-1:0] xr, input logic [IW-1:0] xi,
                          input logic sof, input logic rot, input logic sc,
                          input logic [LW-1:0] er, input logic [LW-1:0] ei);
    int t;
    bit ok;
    exp_t e;
    int idx;
    t = 0;
    @(negedge clk);
    in_valid = 1; in_real = xr; in_imag = xi; in_sof = sof; rot_en = rot;
`ifdef FFT_BFLY_SCALE_EN
    scale_half = sc;
`endif
    forever begin
      #1 ok = in_ready;
      @(posedge clk);
      if (ok) break;
      t++;
      if (t > 300) begin
        check("accept_timeout", 1, 0);
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      idx = sof ? 0 : tb_cnt;
      e.re = er; e.im = ei;
      e.sof = (idx == 0); e.eof = (idx == FB - 1);
      tb_cnt = (idx == FB - 1) ? 0 : idx + 1;
      sb.push_back(e);
      acc_n++;
    end
  endtask

  task automatic send(input logic [IW-1:0] xr, input logic [IW-1:0] xi,
                      input logic sof, input logic rot, input logic sc);
    logic [LW-1:0] er, ei;
    model(xr, xi, rot, sc, er, ei);
    send_exp(xr, xi, sof, rot, sc, er, ei);
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 0; in_sof = 0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    check("drain_empty", sb.size(), 0);
  endtask

  // out_ready pattern driver
  initial begin
    forever begin
      @(negedge clk);
      pc++;
      case (rdy_mode)
        1:       out_ready = (pc % 3 == 0);
        2:       out_ready = 0;
        default: out_ready = 1;
      endcase
    end
  end

  // monitor: handshake rule, hold-while-stalled, scoreboard pop
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rstn) begin
        stalled = 0;
        continue;
      end
      check("in_ready", in_ready,
            !((acc_n - del_n) == 2 && !out_ready));
      if (stalled)
        check("hold", {out_valid, held_sof, out_real, out_imag},
              {1'b1, out_sof, held_re, held_im});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = sb.pop_front();
          check("out_real", out_real, e.re);
          check("out_imag", out_imag, e.im);
          check("out_sof_eof", {out_sof, out_eof}, {e.sof, e.eof});
        end
        del_n++;
        stalled = 0;
      end else begin
        stalled = out_valid;
        held_re = out_real;
        held_im = out_imag;
        held_sof = out_sof;
      end
    end
  end

  initial begin
    logic [IW-1:0] xr, xi;
    logic [LW-1:0] er, ei;

    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_frame_err", frame_err, 0);
    check("rst_sof_eof", {out_sof, out_eof}, 0);
    check("rst_out_data", {out_real, out_imag}, 0);

    // directed beat: 100+20j / 30-5j and 7+3j / 1+1j, rotation on
    xr = '0; xi = '0;
    xr[0*IN_W +: IN_W] = 13'sd100; xi[0*IN_W +: IN_W] = 13'sd20;
    xr[4*IN_W +: IN_W] = 13'sd30;  xi[4*IN_W +: IN_W] = -13'sd5;
    xr[2*IN_W +: IN_W] = 13'sd7;   xi[2*IN_W +: IN_W] = 13'sd3;
    xr[6*IN_W +: IN_W] = 13'sd1;   xi[6*IN_W +: IN_W] = 13'sd1;
    er = '0; ei = '0;
    er[0*OUT_W +: OUT_W] = 14'sd130; ei[0*OUT_W +: OUT_W] = 14'sd15;
    er[2*OUT_W +: OUT_W] = 14'sd8;   ei[2*OUT_W +: OUT_W] = 14'sd4;
    er[4*OUT_W +: OUT_W] = 14'sd70;  ei[4*OUT_W +: OUT_W] = 14'sd25;
    er[6*OUT_W +: OUT_W] = 14'sd2;   ei[6*OUT_W +: OUT_W] = -14'sd6;
    send_exp(xr, xi, 1, 1, 0, er, ei);
    @(negedge clk);
    in_valid = 0; in_sof = 0;
    #1 check("lat_cycle1", out_valid, 0);
    @(negedge clk);
    #1 check("lat_cycle2", out_valid, 1);

    // extremes: -4096 everywhere, +4095 on lanes 4..7
    xr = '0; xi = '0;
    for (int k = 0; k < LANES; k++)
      xr[k*IN_W +: IN_W] = (k >= 4 && k <= 7) ? 13'sd4095 : -13'sd4096;
    er = '0; ei = '0;
    for (int k = 0; k < 4; k++) er[k*OUT_W +: OUT_W] = -14'sd1;
    er[4*OUT_W +: OUT_W] = -14'sd8191;
    er[5*OUT_W +: OUT_W] = -14'sd8191;
    ei[6*OUT_W +: OUT_W] = 14'sd8191;
    ei[7*OUT_W +: OUT_W] = 14'sd8191;
    for (int k = 8; k < 12; k++) er[k*OUT_W +: OUT_W] = -14'sd8192;
    send_exp(xr, xi, 0, 1, 0, er, ei);
    idle();
    drain();

    // backpressure stream of 10 beats
    rdy_mode = 1;
    for (int n = 0; n < 10; n++)
      send(pat(n, 1), pat(n, 2), 0, n[0], 0);
    idle();
    drain();
    check("bp_all_delivered", del_n, acc_n);
    rdy_mode = 0;

    // remainder of the 32-beat frame
    for (int n = 12; n < FB; n++)
      send(pat(n, 3), pat(n, 4), 0, n[1], 0);
    idle();
    drain();
    check("frame_err_clean", frame_err, 0);

    // premature sof at beat 5 of the next frame
    for (int n = 0; n < 6; n++)
      send(pat(n, 5), pat(n, 6), (n == 0 || n == 5), 1, 0);
    idle();
    #1 check("frame_err_set", frame_err, 1);
    @(negedge clk);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
    #1 check("frame_err_clr", frame_err, 0);
    drain();

    // reset with two beats in flight
    rdy_mode = 2;
    send(pat(1, 7), pat(2, 7), 0, 0, 0);
    send(pat(3, 7), pat(4, 7), 0, 0, 0);
    #3 rstn = 0;
    sb.delete();
    acc_n = 0; del_n = 0; tb_cnt = 0; stalled = 0;
    #1 check("rst_mid_out_valid", out_valid, 0);
    in_valid = 0;
    @(negedge clk);
    #1 rstn = 1;
    rdy_mode = 0;
    send(pat(5, 8), pat(6, 8), 0, 1, 0);
    idle();
    #1 check("frame_err_no_sof", frame_err, 1);
    drain();

`ifdef FFT_BFLY_SCALE_EN
    // scaled: 130->65, -3->-1, 8191->4096
    xr = '0; xi = '0;
    xr[0*IN_W +: IN_W] = 13'sd100; xi[0*IN_W +: IN_W] = 13'sd20;
    xr[4*IN_W +: IN_W] = 13'sd30;  xi[4*IN_W +: IN_W] = -13'sd5;
    xr[1*IN_W +: IN_W] = -13'sd1;  xr[5*IN_W +: IN_W] = 13'sd2;
    er = '0; ei = '0;
    er[0*OUT_W +: OUT_W] = 14'sd65;  ei[0*OUT_W +: OUT_W] = 14'sd8;
    er[1*OUT_W +: OUT_W] = 14'sd1;
    er[4*OUT_W +: OUT_W] = 14'sd35;  ei[4*OUT_W +: OUT_W] = 14'sd13;
    er[5*OUT_W +: OUT_W] = -14'sd1;
    send_exp(xr, xi, 0, 1, 1, er, ei);
    xr = '0; xi = '0;
    for (int k = 0; k < LANES; k++)
      xr[k*IN_W +: IN_W] = (k >= 4 && k <= 7) ? 13'sd4095 : -13'sd4096;
    er = '0; ei = '0;
    er[4*OUT_W +: OUT_W] = -14'sd4095;
    er[5*OUT_W +: OUT_W] = -14'sd4095;
    ei[6*OUT_W +: OUT_W] = 14'sd4096;
    ei[7*OUT_W +: OUT_W] = 14'sd4096;
    for (int k = 8; k < 12; k++) er[k*OUT_W +: OUT_W] = -14'sd4096;
    send_exp(xr, xi, 0, 1, 1, er, ei);
    idle();
    drain();
`endif

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
